fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RISC-V core. It owns the program counter and drives it into `INST_MEM`. It captures the combinationally returned `Instruction_Code` into the IF/ID pipeline register for decode. It handles sequential fetch, control-flow redirects from execute, pipeline stalls and flushes, and keeps a retired-fetch counter plus a sticky misaligned-target flag.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`) placed in IF/ID.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset (0 = reset asserted, sampled on `clk` rising edge).
- `stall` in 1: hold PC and IF/ID contents.
- `flush` in 1: replace the IF/ID contents with a bubble.
- `redirect` in 1: load PC from `redirect_target` (taken branch or jump).
- `redirect_target` in 32: new PC value.
- `PC` out 32: fetch address, connected to `INST_MEM.PC`.
- `Instruction_Code` in 32: instruction returned by `INST_MEM` for `PC`.
- `if_id_pc` out 32: PC of the instruction held in IF/ID.
- `if_id_pc_plus4` out 32: `if_id_pc` + 4.
- `if_id_inst` out 32: instruction held in IF/ID.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `misalign_err` out 1: sticky; set when a redirect target has bits [1:0] != 0.
- `fetch_count` out 32: count of instructions accepted into IF/ID.

## Operation
- On reset (`reset`=0 at an edge), the next register values are:
  - `PC` = `RESET_PC`.
  - `if_id_pc` = 0, `if_id_pc_plus4` = 4, `if_id_inst` = `NOP_INST`, `if_id_valid` = 0.
  - `misalign_err` = 0, `fetch_count` = 0.
- PC next-value priority, highest first:
  1. Reset.
  2. `redirect`: `PC` <= {`redirect_target`[31:2], 2'b00}.
  3. `stall`: `PC` holds.
  4. Otherwise: `PC` <= `PC` + 4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- IF/ID next-value priority, highest first:
  1. Reset.
  2. `redirect` or `flush`: bubble. `if_id_inst` = `NOP_INST`, `if_id_valid` = 0, `if_id_pc` and `if_id_pc_plus4` hold.
  3. `stall`: all IF/ID fields hold.
  4. Otherwise: `if_id_pc` <= `PC`, `if_id_pc_plus4` <= `PC` + 4, `if_id_inst` <= `Instruction_Code`, `if_id_valid` <= 1.
- `flush` alone does not change `PC`. With `flush`=1 and `stall`=1, `PC` holds and IF/ID takes a bubble.
- `redirect` overrides `stall` for both `PC` and IF/ID.
- `misalign_err`: set in the cycle after a `redirect` with `redirect_target`[1:0] != 0. It stays set until reset. The redirect itself still proceeds to the word-aligned address.
- `fetch_count`: increments by 1 exactly when IF/ID is loaded by rule 4 (a valid capture). It wraps from 32'hFFFF_FFFF to 0.
- No internal FSM beyond the registers above. The stage is always fetching when not stalled.

## Timing
- `INST_MEM` is combinational: `Instruction_Code` is valid in the same cycle `PC` is presented.
- IF/ID latency is 1 cycle: an instruction at `PC` in cycle N appears on `if_id_*` in cycle N+1.
- Redirect penalty: `redirect` in cycle N gives `PC` = target in cycle N+1. A bubble is in IF/ID in N+1, and the target instruction is valid in IF/ID in N+2.
- After reset deasserts at edge E:
  - `PC` = `RESET_PC` during the first cycle after E.
  - `if_id_valid` first goes to 1 after the following edge, carrying `RESET_PC`.
- Reset asserted mid-stream overrides `stall`, `flush` and `redirect` in the same edge. Nothing in flight survives.
- All outputs are registered. There is no combinational path from any input to any output except `PC` → `INST_MEM` → `Instruction_Code`, which is external.

## Test plan
- Reset, then 4 free-running cycles with `INST_MEM` words 0x00500093, 0x00A00113, 0x002081B3:
  - `PC` steps 0 → 4 → 8 → C.
  - `if_id_inst` = 0x00500093 then 0x00A00113 then 0x002081B3, with `if_id_valid`=1 from the second cycle.
  - `fetch_count` = 3.
- `stall`=1 for 2 cycles while `PC`=8: `PC` stays 8, IF/ID holds 0x00A00113 with `if_id_pc`=4, and `fetch_count` is unchanged. On release, capture resumes at PC 8.
- `redirect`=1, `redirect_target`=0x40 with `stall`=1 in the same cycle:
  - Next cycle: `PC`=0x40, `if_id_valid`=0, `if_id_inst`=0x00000013.
  - Cycle after: `if_id_pc`=0x40, `if_id_valid`=1.
- `redirect_target`=0x22: `PC`=0x20 and `misalign_err`=1. The flag stays 1 through 10 further cycles and clears only on reset.
- `flush`=1 alone at `PC`=0x10: next cycle `PC`=0x14, `if_id_valid`=0, and `fetch_count` does not increment.
- Force `PC` to 0xFFFFFFFC via a redirect, then run 1 cycle: `PC`=0 and `if_id_pc_plus4`=0. Then assert `reset`=0 mid-stall: all outputs return to their reset values after one edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures INST_MEM output into the IF/ID
// register, and handles redirects, stalls, flushes, a fetch counter and a misalignment flag.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] PC,
   input  logic [31:0] Instruction_Code,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_inst,
   output logic        if_id_valid,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_plus4;
   logic        bubble;
   logic        capture;

   assign pc_plus4 = PC + 32'd4;
   assign bubble   = redirect | flush;
   assign capture  = !bubble && !stall;

   // A redirect wins over a stall; the target is forced to a word boundary.
   always_ff @(posedge clk) begin
      if (!reset) begin
         PC <= RESET_PC;
      end else if (redirect) begin
         PC <= {redirect_target[31:2], 2'b00};
      end else if (!stall) begin
         PC <= pc_plus4;
      end
   end

   // A bubble keeps the old PC fields so only the instruction/valid pair changes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if_id_pc       <= 32'd0;
         if_id_pc_plus4 <= 32'd4;
         if_id_inst     <= NOP_INST;
         if_id_valid    <= 1'b0;
      end else if (bubble) begin
         if_id_inst     <= NOP_INST;
         if_id_valid    <= 1'b0;
      end else if (!stall) begin
         if_id_pc       <= PC;
         if_id_pc_plus4 <= pc_plus4;
         if_id_inst     <= Instruction_Code;
         if_id_valid    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         misalign_err <= 1'b0;
         fetch_count  <= 32'd0;
      end else begin
         if (redirect && (redirect_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
         end
         if (capture) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// control traffic, compared against a cycle-level model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] PC;
   logic [31:0] Instruction_Code;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int tests_run = 0;
   int tests_failed = 0;

   // Expected architectural state
   logic [31:0] m_pc;
   logic [31:0] m_ifpc;
   logic [31:0] m_ifp4;
   logic [31:0] m_inst;
   logic        m_valid;
   logic        m_mis;
   logic [31:0] m_cnt;

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .flush(flush),
      .redirect(redirect),
      .redirect_target(redirect_target),
      .PC(PC),
      .Instruction_Code(Instruction_Code),
      .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_inst(if_id_inst),
      .if_id_valid(if_id_valid),
      .misalign_err(misalign_err),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Instruction memory: the three program words, then a hash of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0050_0093;
         32'h0000_0004: mem_word = 32'h00A0_0113;
         32'h0000_0008: mem_word = 32'h0020_81B3;
         default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   assign Instruction_Code = mem_word(PC);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic check_output();
      check_val("PC", PC, m_pc);
      check_val("if_id_pc", if_id_pc, m_ifpc);
      check_val("if_id_pc_plus4", if_id_pc_plus4, m_ifp4);
      check_val("if_id_inst", if_id_inst, m_inst);
      check_val("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check_val("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      check_val("fetch_count", fetch_count, m_cnt);
   endtask

   // Drive one cycle of controls, advance the model across the edge, then check.
   task automatic apply_stimulus(input logic rst_n, input logic st, input logic fl,
                                 input logic rd, input logic [31:0] tgt);
      logic [31:0] cur_pc;
      reset = rst_n;
      stall = st;
      flush = fl;
      redirect = rd;
      redirect_target = tgt;
      @(posedge clk);
      if (!rst_n) begin
         m_pc = RESET_PC;
         m_ifpc = 32'd0;
         m_ifp4 = 32'd4;
         m_inst = NOP_INST;
         m_valid = 1'b0;
         m_mis = 1'b0;
         m_cnt = 32'd0;
      end else begin
         cur_pc = m_pc;
         if (rd) m_pc = tgt & 32'hFFFF_FFFC;
         else if (!st) m_pc = cur_pc + 32'd4;
         if (rd || fl) begin
            m_inst = NOP_INST;
            m_valid = 1'b0;
         end else if (!st) begin
            m_ifpc = cur_pc;
            m_ifp4 = cur_pc + 32'd4;
            m_inst = mem_word(cur_pc);
            m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
         end
         if (rd && (tgt[1:0] != 2'b00)) m_mis = 1'b1;
      end
      #1;
      check_output();
   endtask

   initial begin
      logic [31:0] tgt;
      logic [31:0] cnt_before;
      // Reset and free-run through the three program words
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check_val("reset_pc", PC, 32'h0000_0000);
      check_val("reset_inst", if_id_inst, 32'h0000_0013);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      check_val("run_pc", PC, 32'h0000_000C);
      check_val("run_inst", if_id_inst, 32'h0020_81B3);
      check_val("run_count", fetch_count, 32'd3);

      // Stall with PC at 8
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      check_val("stall_pc", PC, 32'h0000_0008);
      check_val("stall_ifpc", if_id_pc, 32'h0000_0004);
      check_val("stall_inst", if_id_inst, 32'h00A0_0113);
      check_val("stall_count", fetch_count, 32'd2);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      check_val("resume_ifpc", if_id_pc, 32'h0000_0008);

      // Redirect overriding stall
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
      check_val("redir_pc", PC, 32'h0000_0040);
      check_val("redir_valid", {31'd0, if_id_valid}, 32'd0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      check_val("redir_ifpc", if_id_pc, 32'h0000_0040);
      check_val("redir_valid2", {31'd0, if_id_valid}, 32'd1);

      // Misaligned target: aligned redirect plus sticky flag
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0022);
      check_val("mis_pc", PC, 32'h0000_0020);
      check_val("mis_flag", {31'd0, misalign_err}, 32'd1);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      check_val("mis_sticky", {31'd0, misalign_err}, 32'd1);

      // Flush alone at PC 0x10
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check_val("mis_cleared", {31'd0, misalign_err}, 32'd0);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cnt_before = fetch_count;
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      check_val("flush_pc", PC, 32'h0000_0014);
      check_val("flush_count", fetch_count, cnt_before);

      // PC wrap, then reset during a stall
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      check_val("wrap_pc", PC, 32'h0000_0000);
      check_val("wrap_plus4", if_id_pc_plus4, 32'h0000_0000);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
      check_val("rst_mid_pc", PC, 32'h0000_0000);
      check_val("rst_mid_p4", if_id_pc_plus4, 32'h0000_0004);

      // Random control traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       tgt = $urandom();
            1:       tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            default: tgt = $urandom_range(0, 255);
         endcase
         apply_stimulus($urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, tgt);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
